// File: rtl/frame_minmax.sv
// frame_minmax: streaming signed min/max/count tracker.
//
// Consumes N-bit two's-complement samples on a valid/ready handshake and
// produces one result per frame (frames end on the sample with in_last).
// Two slt units supply the signed "new minimum" / "new maximum" decisions.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous abort of the current frame and any pending result
//   in_valid   sample present
//   in_ready   block accepts a sample this cycle (high while accumulating)
//   in_data    signed sample
//   in_last    accepted sample closes the frame
//   out_valid  frame result available (high while reporting)
//   out_ready  downstream takes the result
//   out_min    signed minimum of the frame
//   out_max    signed maximum of the frame
//   out_count  samples in the frame, saturating at 2^COUNT_W-1

// slt: combinational full-width signed less-than, lt = (a < b).
module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  assign lt = ($signed(a) < $signed(b));

endmodule

module frame_minmax #(
  parameter int N       = 32,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_min,
  output logic [N-1:0]       out_max,
  output logic [COUNT_W-1:0] out_count
);

  typedef enum logic {
    S_ACCUM  = 1'b0,
    S_REPORT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               first_q, first_d;
  logic [N-1:0]       min_q, min_d;
  logic [N-1:0]       max_q, max_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic accept;
  logic release_res;
  logic new_min;
  logic new_max;
  logic count_full;

  // Candidate-minimum compare: sample strictly below the running minimum.
  slt #(.N(N)) u_slt_min (
    .a  (in_data),
    .b  (min_q),
    .lt (new_min)
  );

  // Candidate-maximum compare: running maximum strictly below the sample.
  slt #(.N(N)) u_slt_max (
    .a  (max_q),
    .b  (in_data),
    .lt (new_max)
  );

  assign in_ready    = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_REPORT);
  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;
  assign count_full  = (count_q == {COUNT_W{1'b1}});

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;

  // Next-state logic. The result registers double as the running
  // accumulators; they are only touched by an accept, so they stay stable
  // while a result waits in S_REPORT (in_ready is low there).
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;

    if (clear) begin
      // Abort dominates any accept or release in the same cycle; min/max
      // are deliberately held.
      state_d = S_ACCUM;
      first_d = 1'b1;
      count_d = '0;
    end else begin
      if (accept) begin
        if (first_q) begin
          min_d   = in_data;
          max_d   = in_data;
          count_d = {{(COUNT_W-1){1'b0}}, 1'b1};
          first_d = 1'b0;
        end else begin
          if (new_min) begin
            min_d = in_data;
          end
          if (new_max) begin
            max_d = in_data;
          end
          if (!count_full) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          end
        end
        if (in_last) begin
          state_d = S_REPORT;
          first_d = 1'b1;
        end
      end
      if (release_res) begin
        state_d = S_ACCUM;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ACCUM;
      first_q <= 1'b1;
      min_q   <= '0;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_frame_minmax.sv
// tb_frame_minmax: directed bench for frame_minmax.
// Main instance uses N=32, COUNT_W=16; a second instance with COUNT_W=2
// exercises counter saturation. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active edge.
module tb_frame_minmax;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_valid2;
  logic        in_ready;
  logic        in_ready2;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_valid2;
  logic        out_ready;
  logic [31:0] out_min;
  logic [31:0] out_max;
  logic [15:0] out_count;
  logic [31:0] out_min2;
  logic [31:0] out_max2;
  logic [1:0]  out_count2;

  int totalChecks;
  int badChecks;

  frame_minmax #(.N(32), .COUNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
  );

  frame_minmax #(.N(32), .COUNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_min   (out_min2),
    .out_max   (out_max2),
    .out_count (out_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one sample (called just after a falling edge); the sample is
  // taken on the following rising edge. Returns at the next falling edge.
  task automatic applyStimulus(input bit sel, input logic [31:0] d, input bit last);
    in_data = d;
    in_last = last;
    if (sel) begin
      in_valid2 = 1'b1;
      checkOutput("sat_in_ready", {31'b0, in_ready2}, 32'd1);
    end else begin
      in_valid = 1'b1;
      checkOutput("in_ready", {31'b0, in_ready}, 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] mn, input logic [31:0] mx, input logic [31:0] cnt);
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_min"}, out_min, mn);
    checkOutput({tag, "_max"}, out_max, mx);
    checkOutput({tag, "_count"}, {16'b0, out_count}, cnt);
  endtask

  initial begin
    totalChecks = 0;
    badChecks   = 0;
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #3;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_min", out_min, 32'd0);
    checkOutput("rst_count", {16'b0, out_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic frame
    applyStimulus(1'b0, 32'd5, 1'b0);
    applyStimulus(1'b0, -32'sd3, 1'b0);
    applyStimulus(1'b0, 32'd7, 1'b0);
    applyStimulus(1'b0, -32'sd8, 1'b1);
    checkResult("basic", -32'sd8, 32'd7, 32'd4);
    checkOutput("basic_busy", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("basic_released", {31'b0, out_valid}, 32'd0);
    checkOutput("basic_ready_back", {31'b0, in_ready}, 32'd1);

    // Sign boundaries with a tie on the maximum
    applyStimulus(1'b0, 32'h8000_0000, 1'b0);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'h7FFF_FFFF, 1'b1);
    checkResult("sign", 32'h8000_0000, 32'h7FFF_FFFF, 32'd4);
    @(negedge clk);

    // Single-sample frame
    applyStimulus(1'b0, 32'hFFFF_FFFE, 1'b1);
    checkResult("single", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1);
    @(negedge clk);

    // Backpressure: result held, no sample taken while stalled
    out_ready = 1'b0;
    applyStimulus(1'b0, 32'd10, 1'b0);
    applyStimulus(1'b0, 32'd20, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'd77;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkResult("stall", 32'd10, 32'd20, 32'd2);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_released", {31'b0, out_valid}, 32'd0);
    checkOutput("stall_ready_back", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkResult("after_stall", 32'd77, 32'd77, 32'd1);
    @(negedge clk);

    // Clear dominates a simultaneous accept
    applyStimulus(1'b0, 32'd100, 1'b0);
    applyStimulus(1'b0, 32'd200, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd999;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("clear_count", {16'b0, out_count}, 32'd0);
    checkOutput("clear_min_held", out_min, 32'd100);
    applyStimulus(1'b0, 32'd3, 1'b1);
    checkResult("clear", 32'd3, 32'd3, 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-frame
    applyStimulus(1'b0, 32'd50, 1'b0);
    applyStimulus(1'b0, 32'd60, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_min", out_min, 32'd0);
    checkOutput("arst_max", out_max, 32'd0);
    checkOutput("arst_count", {16'b0, out_count}, 32'd0);
    checkOutput("arst_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("arst_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b0, 32'd4, 1'b1);
    checkResult("arst_frame", 32'd4, 32'd4, 32'd1);
    @(negedge clk);

    // Count saturation on the COUNT_W=2 instance
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, i, (i == 5));
    end
    checkOutput("sat_valid", {31'b0, out_valid2}, 32'd1);
    checkOutput("sat_count", {30'b0, out_count2}, 32'd3);
    checkOutput("sat_min", out_min2, 32'd1);
    checkOutput("sat_max", out_max2, 32'd5);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/frame_minmax.md
# frame_minmax

Streaming signed min/max tracker that consumes N-bit samples over a valid/ready handshake and reports the minimum, maximum and sample count of each frame. Frames are delimited by `in_last`. It sits directly downstream of the signed less-than comparator `slt`: it instantiates two `slt #(.N(N))` units, one for the candidate-minimum compare and one for the candidate-maximum compare. The block turns those combinational decisions into registered per-frame statistics for the next stage.

## Interface
Parameters:
- `N`, 32, sample width; all data is two's-complement signed.
- `COUNT_W`, 16, width of the per-frame sample counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted when 0).
- `clear`  input  1  synchronous abort; discards the current frame and any pending result.
- `in_valid`  input  1  sample present.
- `in_ready`  output  1  block accepts a sample this cycle.
- `in_data`  input  N  signed sample.
- `in_last`  input  1  the accepted sample is the final sample of the frame.
- `out_valid`  output  1  frame result available.
- `out_ready`  input  1  downstream accepts the result.
- `out_min`  output  N  signed minimum of the frame.
- `out_max`  output  N  signed maximum of the frame.
- `out_count`  output  COUNT_W  number of samples in the frame, saturating.

## Operation
- States: `S_ACCUM` and `S_REPORT`.
  - `in_ready = (state == S_ACCUM)`.
  - `out_valid = (state == S_REPORT)`.
- An accept is `in_valid && in_ready`. A release is `out_valid && out_ready`.
- Internal flag `first` is 1 when no sample of the current frame has been accepted yet.
- Accept with `first = 1`:
  - min ← `in_data`, max ← `in_data`, count ← 1, `first` ← 0.
- Accept with `first = 0`:
  - min ← `in_data` if `slt(in_data, min)`; otherwise min is unchanged.
  - max ← `in_data` if `slt(max, in_data)`; otherwise max is unchanged.
  - Equal values change nothing.
  - count ← count + 1, saturating at 2^COUNT_W − 1.
- Accept with `in_last = 1`:
  - The final min, max and count include this sample.
  - State → `S_REPORT`, `first` ← 1.
- Release: state → `S_ACCUM`. The `out_*` data registers keep their values until the next frame overwrites them.
- `in_data` and `in_last` are ignored whenever there is no accept.
- `clear = 1`:
  - State → `S_ACCUM`, `first` ← 1, count ← 0.
  - min and max are held.
  - `clear` wins over a simultaneous accept (the sample is dropped) and over a simultaneous release.
- Comparisons are full-width signed. There is no unsigned mode.

## Timing
- Reset (`rst = 0`, takes effect immediately, asynchronously):
  - State `S_ACCUM`, `first = 1`.
  - `out_min = 0`, `out_max = 0`, `out_count = 0`.
  - `out_valid = 0`, `in_ready = 1` (valid once `rst` is released).
  - Reset mid-frame loses the partial frame. Reset in `S_REPORT` drops the pending result.
- Result latency: `out_valid` rises on the clock edge that accepts the `in_last` sample. The result is visible one cycle after that accept.
- While `out_valid = 1` and `out_ready = 0`, `out_min`, `out_max` and `out_count` are stable and `in_ready = 0`.
- After a release, `in_ready` is 1 in the next cycle. This gives one bubble cycle between frames, which is the minimum inter-frame gap.
- Throughput within a frame: one sample per cycle.
- Neither `in_ready` nor `out_valid` depends combinationally on `in_valid` or `out_ready`.

## Test plan
- **Basic frame:** samples 5, −3, 7, −8 (last on −8), `out_ready = 1`.
  - One cycle later: `out_valid = 1`, `out_min = −8`, `out_max = 7`, `out_count = 4`.
  - `in_ready` returns to 1 the following cycle.
- **Sign boundaries:** samples 0x80000000, 0x7FFFFFFF, −1, 0x7FFFFFFF (last).
  - min = 0x80000000, max = 0x7FFFFFFF, count = 4. Ties leave values unchanged.
- **Single-sample frame:** one sample 0xFFFFFFFE with `in_last`.
  - min = max = 0xFFFFFFFE (−2), count = 1.
- **Backpressure:** hold `out_ready = 0` for 5 cycles after a frame completes, with `in_valid = 1` and new data.
  - `out_*` stay constant and `in_ready = 0`; no sample is accepted.
  - Raising `out_ready` releases the result. The next frame starts accepting one cycle later.
- **Clear and reset:**
  - Accept 100, 200, then pulse `clear` together with a valid sample 999, then send 3 (last). Result: min = max = 3, count = 1.
  - Separately, drive `rst = 0` mid-frame: all outputs go to 0 immediately and `in_ready = 1` after release.
- **Count saturation:** with `COUNT_W = 2`, send a 5-sample frame 1, 2, 3, 4, 5 (last).
  - `out_count = 3`, min = 1, max = 5.
